// File: rtl/imem_loader.sv
// imem_loader: boot loader streaming a byte image into IMEM, optional checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_nrst,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        RUN,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK,
`endif
        ERROR
    } state_t;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHECK;
`else
    localparam state_t FIN = RUN;
`endif
    state_t state, state_n;
    logic [7:0] hdr_hi;
    logic [15:0] n_full;
    logic [CNT_WIDTH-1:0] n_q, word_idx;
    logic [1:0] byte_cnt;
    logic [23:0] asm_q;
    logic xfer, last, acc_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif
    assign xfer   = in_valid & in_ready;
    assign n_full = {hdr_hi, in_data};
    assign last   = word_idx == n_q - CNT_WIDTH'(1);
    assign mem_we = state == WRITE;
    // state register
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) state <= HDR_HI;
        else state <= state_n;
    // next-state decode and accepting-state lookahead for the registered in_ready
    always_comb begin
        state_n = state;
        case (state)
            HDR_HI: state_n = xfer ? HDR_LO : HDR_HI;
            HDR_LO: if (xfer) state_n = n_full == 16'd0 ? FIN : 32'(n_full) > 32'(MAX_WORDS) ? ERROR : DATA;
            DATA:   state_n = xfer && byte_cnt == 2'd3 ? WRITE : DATA;
            WRITE:  state_n = last ? FIN : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:  if (xfer) state_n = in_data == csum ? RUN : ERROR;
`endif
            default: state_n = state;
        endcase
        acc_n = state_n == HDR_HI || state_n == HDR_LO || state_n == DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc_n = acc_n || state_n == CHECK;
`endif
    end
    // registered status outputs, all low while in reset
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            in_ready  <= 1'b0;
            core_nrst <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            in_ready  <= acc_n;
            core_nrst <= state_n == RUN;
            done      <= state_n == RUN;
            error     <= state_n == ERROR;
        end
    // header latch, word assembly, counters and the held IMEM address/data
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            hdr_hi    <= '0;
            n_q       <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (xfer && state == HDR_HI) hdr_hi <= in_data;
            if (xfer && state == HDR_LO) begin
                n_q      <= CNT_WIDTH'(n_full);
                word_idx <= '0;
                byte_cnt <= '0;
            end
            if (xfer && state == DATA) begin
                asm_q    <= {asm_q[15:0], in_data};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_addr  <= 32'({word_idx, 2'b00});
                    mem_wdata <= {asm_q, in_data};
                end
            end
            if (state == WRITE) word_idx <= word_idx + CNT_WIDTH'(1);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
    // running XOR of data bytes, cleared when the header completes
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) csum <= '0;
        else if (xfer && state == HDR_LO) csum <= '0;
        else if (xfer && state == DATA) csum <= csum ^ in_data;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader
module tb_imem_loader;
    logic clk = 0, nrst = 0, in_valid = 0, in_ready, mem_we, core_nrst, done, error;
    logic [7:0] in_data = 0;
    logic [31:0] mem_addr, mem_wdata;
    int checks = 0, fails = 0, cyc = 0, wr_n = 0, rdy_bad = 0;
    logic [31:0] wr_addr[0:511], wr_data[0:511];
    logic [7:0] img[$];
    logic [7:0] cs;
    int t0, bad;

    imem_loader dut (.clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_nrst(core_nrst),
        .done(done), .error(error));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // capture IMEM writes away from the active edge
    always @(negedge clk)
        if (mem_we) begin
            if (wr_n < 512) begin
                wr_addr[wr_n] = mem_addr;
                wr_data[wr_n] = mem_wdata;
            end
            wr_n = wr_n + 1;
            if (in_ready) rdy_bad = rdy_bad + 1;
        end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        nrst = 0;
        repeat (3) @(negedge clk);
        nrst = 1;
        @(negedge clk);
        wr_n = 0;
        rdy_bad = 0;
    endtask

    task automatic send(input logic [7:0] b);
        in_data = b;
        in_valid = 1;
        for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
        if (!in_ready) check("ready_timeout", {31'b0, in_ready}, 1);
        @(negedge clk);
    endtask

    task automatic start_img(input logic [15:0] n);
        img.delete();
        img.push_back(n[15:8]);
        img.push_back(n[7:0]);
        cs = 0;
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            img.push_back(w[31-8*k -: 8]);
            cs ^= w[31-8*k -: 8];
        end
    endtask

    task automatic finish_img();
`ifdef IMEM_LOADER_CHECKSUM_EN
        img.push_back(cs);
`endif
    endtask

    task automatic send_img(input bit stall);
        foreach (img[i]) begin
            send(img[i]);
            if (stall) begin
                in_valid = 0;
                @(negedge clk);
            end
        end
        in_valid = 0;
    endtask

    task automatic wait_flag(input bit want_err);
        for (int t = 0; t < 50 && !(want_err ? error : done); t++) @(negedge clk);
    endtask

    task automatic check_two(input string tag);
        check({tag, "_wr_n"}, wr_n, 2);
        check({tag, "_a0"}, wr_addr[0], 32'h0);
        check({tag, "_d0"}, wr_data[0], 32'h12345678);
        check({tag, "_a1"}, wr_addr[1], 32'h4);
        check({tag, "_d1"}, wr_data[1], 32'h9ABCDEF0);
        check({tag, "_done"}, {31'b0, done}, 1);
        check({tag, "_core"}, {31'b0, core_nrst}, 1);
        check({tag, "_rdy_in_wr"}, rdy_bad, 0);
    endtask

    initial begin
        // reset: outputs quiet while held, in_ready one edge after release
        nrst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_outs", {in_ready, mem_we, core_nrst, done, error, mem_addr[0], mem_wdata[0]}, 0);
        end
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        nrst = 1;
        #1 check("rel_rdy0", {31'b0, in_ready}, 0);
        @(negedge clk);
        check("rel_rdy1", {31'b0, in_ready}, 1);

        // two-word image with in_valid held high
        start_img(2); add_word(32'h12345678); add_word(32'h9ABCDEF0); finish_img();
        wr_n = 0;
        t0 = cyc;
        send_img(0);
        wait_flag(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("two_t_done", cyc - t0, 13);
`else
        check("two_t_done", cyc - t0, 12);
`endif
        check_two("two");
        check("run_rdy", {31'b0, in_ready}, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // bad checksum byte
        do_reset();
        start_img(2); add_word(32'h12345678); add_word(32'h9ABCDEF0);
        img.push_back(cs ^ 8'hFF);
        send_img(0);
        wait_flag(1);
        check("cs_bad_err", {error, done, core_nrst}, 3'b100);
`endif

        // stalled stream
        do_reset();
        start_img(2); add_word(32'h12345678); add_word(32'h9ABCDEF0); finish_img();
        send_img(1);
        wait_flag(0);
        check_two("stall");

        // empty image
        do_reset();
        start_img(0); finish_img();
        send_img(0);
        wait_flag(0);
        check("n0_done", {done, core_nrst, error}, 3'b110);
        check("n0_wr_n", wr_n, 0);

        // oversize header
        do_reset();
        start_img(16'h0101);
        send_img(0);
        wait_flag(1);
        in_data = 8'h55;
        in_valid = 1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) bad++;
        end
        in_valid = 0;
        check("ovf_err", {error, core_nrst, done}, 3'b100);
        check("ovf_rdy", bad, 0);
        check("ovf_wr_n", wr_n, 0);

        // max fill
        do_reset();
        start_img(16'd256);
        for (int i = 0; i < 256; i++) add_word(i);
        finish_img();
        send_img(0);
        wait_flag(0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== 32'(i)) bad++;
        check("fill_wr_n", wr_n, 256);
        check("fill_all", bad, 0);
        check("fill_last_a", wr_addr[255], 32'h3FC);
        check("fill_last_d", wr_data[255], 32'hFF);
        check("fill_done", {31'b0, done}, 1);

        // reset mid-load, then a fresh one-word load
        do_reset();
        start_img(3); add_word(32'h01020304); add_word(32'h05060708); add_word(32'h090A0B0C);
        for (int i = 0; i < 8; i++) send(img[i]);
        in_valid = 0;
        @(negedge clk);
        nrst = 0;
        #1 check("mid_outs", {in_ready, mem_we, core_nrst, done, error}, 0);
        check("mid_wdata", mem_wdata, 0);
        @(negedge clk);
        nrst = 1;
        @(negedge clk);
        check("mid_rdy", {31'b0, in_ready}, 1);
        wr_n = 0;
        start_img(1); add_word(32'hAABBCCDD); finish_img();
        send_img(0);
        wait_flag(0);
        check("mid_wr_n", wr_n, 1);
        check("mid_a0", wr_addr[0], 0);
        check("mid_d0", wr_data[0], 32'hAABBCCDD);
        check("mid_done", {31'b0, done}, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
